kernel_loader: RTL and testbench

KERNEL_LOADER -- requirements
Module: kernel_loader

---
 rtl/kernel_loader_pkg.sv | 15 +
 rtl/kernel_loader_if.sv | 37 +++
 rtl/kernel_loader_chksum_acc.sv | 29 ++
 rtl/kernel_loader.sv | 132 +++++++++++++
 tb/tb_kernel_loader.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/kernel_loader_pkg.sv
// Shared types and default sizes for the kernel weight loader.
package npu_kernel_pkg;

  localparam int KERNEL_REG_SIZE_D   = 64;
  localparam int KERNEL_ADDR_WIDTH_D = 6;
  localparam int WEIGHT_WIDTH_D      = 8;
  localparam int CHKSUM_W            = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } kl_state_e;

endpackage

// File: rtl/kernel_loader_if.sv
// Control, weight stream and kernel register write bundle.
interface kernel_loader_if #(
  parameter int AW = 6,
  parameter int WW = 8
);

  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   num_weights;
  logic          s_valid;
  logic [WW-1:0] s_data;
  logic          s_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [WW-1:0] wr_data;
  logic          busy;
  logic          done;
  logic          err;
  logic [15:0]   chksum;

  modport master (
    output start, base_addr, num_weights,
    output s_valid, s_data,
    input  s_ready,
    input  wr_en, wr_addr, wr_data,
    input  busy, done, err, chksum
  );

  modport slave (
    input  start, base_addr, num_weights,
    input  s_valid, s_data,
    output s_ready,
    output wr_en, wr_addr, wr_data,
    output busy, done, err, chksum
  );

endinterface

// File: rtl/kernel_loader_chksum_acc.sv
// 16-bit wrap-around sum of accepted weights, cleared on each new load.
module kernel_chksum_acc
  import npu_kernel_pkg::*;
#(
  parameter int WW = WEIGHT_WIDTH_D
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_clr,
  input  logic                i_en,
  input  logic [WW-1:0]       i_data,
  output logic [CHKSUM_W-1:0] o_sum
);

  logic [CHKSUM_W-1:0] r_sum;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_sum <= '0;
    end else if (i_clr) begin
      r_sum <= '0;
    end else if (i_en) begin
      r_sum <= r_sum + CHKSUM_W'(i_data);
    end
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/kernel_loader.sv
// Streams weights into the kernel register file from a base address.
// Define KERNEL_LOADER_CHKSUM_EN to enable the weight checksum.
module kernel_loader
  import npu_kernel_pkg::*;
#(
  parameter int KERNEL_REG_SIZE   = KERNEL_REG_SIZE_D,
  parameter int KERNEL_ADDR_WIDTH = KERNEL_ADDR_WIDTH_D,
  parameter int WEIGHT_WIDTH      = WEIGHT_WIDTH_D
) (
  input  logic            i_clk,
  input  logic            i_rst,
  kernel_loader_if.slave  bus
);

  localparam int AW = KERNEL_ADDR_WIDTH;
  localparam int WW = WEIGHT_WIDTH;

  kl_state_e r_state;
  kl_state_e w_next;

  logic [AW-1:0]       r_ptr;
  logic [AW:0]         r_rem;
  logic                r_wr_en;
  logic [AW-1:0]       r_wr_addr;
  logic [WW-1:0]       r_wr_data;
  logic                r_err;
  logic                w_s_ready;
  logic                w_busy;
  logic                w_done;
  logic                w_num_ok;
  logic                w_acc_start;
  logic                w_rej_start;
  logic                w_beat;
  logic                w_last;
  logic [CHKSUM_W-1:0] w_chksum;

  assign w_num_ok = (bus.num_weights != '0) &&
    (bus.num_weights <= (AW+1)'(KERNEL_REG_SIZE));

  assign w_acc_start = (r_state == IDLE) &&
    bus.start && w_num_ok;
  assign w_rej_start = (r_state == IDLE) &&
    bus.start && !w_num_ok;

  assign w_beat = bus.s_valid && w_s_ready;
  assign w_last = (r_rem == (AW+1)'(1));

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_acc_start) w_next = LOAD;
      LOAD: if (w_beat && w_last) w_next = DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_s_ready = 1'b0;
    w_busy    = 1'b0;
    w_done    = 1'b0;
    unique case (1'b1)
      (r_state == LOAD): begin
        w_s_ready = 1'b1;
        w_busy    = 1'b1;
      end
      (r_state == DONE): begin
        w_busy = 1'b1;
        w_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Write port lags acceptance by one cycle; pointer wraps mod SIZE
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_ptr     <= '0;
      r_rem     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_err     <= 1'b0;
    end else begin
      r_wr_en <= w_beat;
      r_err   <= w_rej_start;
      if (w_beat) begin
        r_wr_addr <= r_ptr;
        r_wr_data <= bus.s_data;
        r_ptr     <= r_ptr + AW'(1);
        r_rem     <= r_rem - (AW+1)'(1);
      end
      if (w_acc_start) begin
        r_ptr <= bus.base_addr;
        r_rem <= bus.num_weights;
      end
    end
  end

`ifdef KERNEL_LOADER_CHKSUM_EN
  kernel_chksum_acc #(
    .WW (WW)
  ) u_chksum (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (w_acc_start),
    .i_en   (w_beat),
    .i_data (bus.s_data),
    .o_sum  (w_chksum)
  );
`else
  assign w_chksum = '0;
`endif

  assign bus.s_ready = w_s_ready;
  assign bus.busy    = w_busy;
  assign bus.done    = w_done;
  assign bus.err     = r_err;
  assign bus.wr_en   = r_wr_en;
  assign bus.wr_addr = r_wr_addr;
  assign bus.wr_data = r_wr_data;
  assign bus.chksum  = w_chksum;

endmodule

// File: tb/tb_kernel_loader.sv
// Directed and randomized checks of kernel_loader against a beat-list model.
module tb_kernel_loader;

  localparam int SIZE = 64;
  localparam int AW   = 6;
  localparam int WW   = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   w_q[$];
  int   v_q[$];

  kernel_loader_if #(.AW(AW), .WW(WW)) bus ();

  kernel_loader #(
    .KERNEL_REG_SIZE   (SIZE),
    .KERNEL_ADDR_WIDTH (AW),
    .WEIGHT_WIDTH      (WW)
  ) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_sum(input int s);
`ifdef KERNEL_LOADER_CHKSUM_EN
    return s & 16'hffff;
`else
    return 0;
`endif
  endfunction

  // One full load: expected write k goes to (base+k) mod SIZE,
  // done lands the cycle after the n-th accepted beat.
  task automatic load(input int base, input int n,
                      input int vprob, input bit inj);
    int k;
    int cyc;
    int sum;
    bit v;
    logic [WW-1:0] d;
    step();
    bus.start       = 1'b1;
    bus.base_addr   = AW'(base);
    bus.num_weights = (AW+1)'(n);
    bus.s_valid     = 1'b0;
    step();
    bus.start = 1'b0;
    chk("entry_busy", 32'(bus.busy), 1);
    chk("entry_ready", 32'(bus.s_ready), 1);
    chk("entry_wr_en", 32'(bus.wr_en), 0);
    chk("entry_err", 32'(bus.err), 0);
    k   = 0;
    cyc = 0;
    sum = 0;
    while (k < n) begin
      if (cyc >= 400) begin
        checks++;
        errors++;
        $error("FAIL load_timeout observed=%0d expected=%0d",
               k, n);
        break;
      end
      if (cyc < v_q.size()) v = (v_q[cyc] != 0);
      else v = ($urandom_range(0, 99) < vprob);
      if (k < w_q.size()) d = WW'(w_q[k]);
      else d = WW'($urandom);
      bus.s_valid = v;
      bus.s_data  = d;
      if (inj && cyc == 1) begin
        bus.start       = 1'b1;
        bus.base_addr   = AW'(20);
        bus.num_weights = (AW+1)'(5);
      end
      step();
      bus.start = 1'b0;
      cyc++;
      chk("wr_en", 32'(bus.wr_en), 32'(v));
      if (v) begin
        chk("wr_addr", 32'(bus.wr_addr), (base + k) % SIZE);
        chk("wr_data", 32'(bus.wr_data), 32'(d));
        sum += int'(d);
        k++;
      end
      chk("busy", 32'(bus.busy), 1);
      chk("err_quiet", 32'(bus.err), 0);
      if (k < n) begin
        chk("ready", 32'(bus.s_ready), 1);
        chk("done_early", 32'(bus.done), 0);
      end else begin
        chk("done", 32'(bus.done), 1);
        chk("ready_done", 32'(bus.s_ready), 0);
        chk("chksum", 32'(bus.chksum), exp_sum(sum));
      end
    end
    bus.s_valid = 1'b0;
    step();
    chk("post_done", 32'(bus.done), 0);
    chk("post_busy", 32'(bus.busy), 0);
    chk("post_wr_en", 32'(bus.wr_en), 0);
    chk("post_chksum", 32'(bus.chksum), exp_sum(sum));
    w_q.delete();
    v_q.delete();
  endtask

  task automatic bad_start(input int n);
    step();
    bus.start       = 1'b1;
    bus.base_addr   = AW'($urandom);
    bus.num_weights = (AW+1)'(n);
    step();
    bus.start = 1'b0;
    chk("err_pulse", 32'(bus.err), 1);
    chk("err_busy", 32'(bus.busy), 0);
    chk("err_wr_en", 32'(bus.wr_en), 0);
    chk("err_ready", 32'(bus.s_ready), 0);
    step();
    chk("err_clear", 32'(bus.err), 0);
    chk("err_busy2", 32'(bus.busy), 0);
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    rst_n           = 1'b0;
    bus.start       = 1'b0;
    bus.base_addr   = '0;
    bus.num_weights = '0;
    bus.s_valid     = 1'b0;
    bus.s_data      = '0;
    step();
    step();
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_ready", 32'(bus.s_ready), 0);
    chk("rst_wr_en", 32'(bus.wr_en), 0);
    chk("rst_wr_addr", 32'(bus.wr_addr), 0);
    chk("rst_wr_data", 32'(bus.wr_data), 0);
    chk("rst_chksum", 32'(bus.chksum), 0);
    rst_n = 1'b1;

    w_q = '{3, 1, 5, 2, 4, 2, 5, 1, 3};
    load(0, 9, 100, 1'b0);

    w_q = '{10, 11, 12, 13};
    load(62, 4, 100, 1'b0);

    bad_start(0);
    bad_start(65);

    v_q = '{1, 0, 0, 1, 0, 1};
    load(7, 3, 100, 1'b0);

    load(33, 6, 100, 1'b1);

    // Reset after two of five beats
    step();
    bus.start       = 1'b1;
    bus.base_addr   = AW'(5);
    bus.num_weights = (AW+1)'(5);
    step();
    bus.start   = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h21;
    step();
    bus.s_data = 8'h22;
    step();
    chk("rst_mid_addr", 32'(bus.wr_addr), 6);
    bus.s_valid = 1'b0;
    rst_n       = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rstm_ready", 32'(bus.s_ready), 0);
    chk("rstm_busy", 32'(bus.busy), 0);
    chk("rstm_done", 32'(bus.done), 0);
    chk("rstm_wr_en", 32'(bus.wr_en), 0);
    chk("rstm_chksum", 32'(bus.chksum), 0);
    step();
    chk("rstm_done2", 32'(bus.done), 0);
    load(40, 2, 100, 1'b0);

    for (int i = 0; i < 6; i++) begin
      load(int'($urandom_range(0, SIZE - 1)),
           int'($urandom_range(1, SIZE)), 70, 1'b0);
    end
    load(int'($urandom_range(0, SIZE - 1)), SIZE, 100, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
